ps2_kbd_matrix: RTL and testbench
=================================

Name: ps2_kbd_matrix

Overview:
- Upstream stage of the LM80C keyboard path.
- Receives PS/2 keyboard frames and decodes make/break scancodes, including E0 and F0 prefixes.
- Maintains an 8x8 active-low key matrix that drives the computer's KM[7:0] rows. The PSG port-B column select reads this matrix.
- Runs entirely in the sys_clock domain.

Parameters:
- FILTER_LEN, 8: sys_clock cycles a synchronized ps2_clk level must hold before it is accepted.
- TIMEOUT_CYC, 50000: idle cycles mid-frame after which the bit counter is abandoned. Counter is 16 bits wide.

Ports:
- sys_clock input 1: system clock.
- reset_n input 1: asynchronous active-low reset.
- ps2_clk input 1: raw PS/2 clock from the keyboard, asynchronous.
- ps2_data input 1: raw PS/2 data, asynchronous.
- clr_all input 1: synchronous; releases every key on the next cycle.
- KM output 8x8 (unpacked [7:0] KM[7:0]): key matrix, active-low. KM[r][c]=0 means key held.
- key_strobe output 1: one-cycle pulse per accepted byte.
- scancode output 8: last accepted byte. Valid when key_strobe is high, held otherwise.
- frame_err output 1: one-cycle pulse on a parity, start or stop error, or on a timeout.

Behaviour:
- Reset (async assert, sync deassert to sys_clock):
  - All KM bits 1; key_strobe=0; scancode=8'h00; frame_err=0.
  - Receiver and decoder FSM go to IDLE.
- Input conditioning:
  - ps2_clk and ps2_data each pass a 2-FF synchronizer.
  - The filtered clock changes only after FILTER_LEN consecutive equal samples.
  - A bit is sampled from synchronized ps2_data on the filtered falling edge.
- Receiver: 11-bit frame, counted 0..10.
  - Bit 0 start: must be 0, else frame_err and counter reset.
  - Bits 1-8: data, LSB first.
  - Bit 9: odd parity over the data bits plus this bit.
  - Bit 10 stop: must be 1.
  - Good frame: key_strobe and scancode update 1 cycle after the stop-bit edge.
  - Bad parity or stop: frame_err pulse, byte discarded, KM unchanged.
- Timeout:
  - The counter runs while bit count is not 0 and clears on each filtered falling edge.
  - Reaching TIMEOUT_CYC: bit count to 0, frame_err pulse, partial byte discarded.
- Decoder FSM, advanced only on good bytes:
  - IDLE: E0 goes to EXT; F0 goes to BRK; any other code applies a make from the base table, then IDLE.
  - EXT: F0 goes to EXT_BRK; any other code applies a make from the extended table, then IDLE.
  - BRK: any code applies a break from the base table, then IDLE.
  - EXT_BRK: any code applies a break from the extended table, then IDLE.
  - Codes AA, EE, FA, FE, 00, FF in IDLE are ignored (stay IDLE) and do not change KM.
  - A frame_err or timeout returns the FSM to IDLE.
- Matrix update:
  - A make clears KM[row][col]; a break sets it. Written 1 cycle after key_strobe.
  - Codes with no table entry are ignored.
  - Make of an already-held key: no change. Break of an unheld key: no change.
- clr_all: sets all 64 bits to 1. If it coincides with a make, clr_all wins for that cycle.
- Mapping (row,col). The minimum set below must exist; other entries are filled in per the LM80C key layout:
  - Base table:
    - 1C 'A' -> (1,2)
    - 1B 'S' -> (1,5)
    - 5A Enter -> (0,1)
    - 12 LShift -> (1,7)
    - 59 RShift -> (6,4)
    - 29 Space -> (7,4)
    - 66 Backspace -> (0,0)
    - 16 '1' -> (7,0)
  - Extended table:
    - E0 75 Up -> (0,3)
    - E0 72 Down -> (0,7)
    - E0 6B Left -> (0,2)
    - E0 74 Right -> (0,6)
- LShift and RShift are distinct entries. Releasing one does not release the other.

Test Plan:
- Reset, then a frame for 1C (data 00111000 LSB-first, parity 0, stop 1) -> key_strobe once, scancode=1C, KM[1]=8'hFB, all other rows FF.
- Send F0 then 1C -> two strobes, KM[1] returns to FF, FSM in IDLE.
- Send E0 75, then E0 F0 75 -> KM[0]=8'hF7, then KM[0]=8'hFF. Sending 75 alone (no E0) leaves KM unchanged.
- Frame for 5A with parity bit inverted -> frame_err pulse, no key_strobe, KM[0]=FF. A following good 5A clears KM[0] bit 1.
- Stop clocking after 4 bits for TIMEOUT_CYC+10 cycles -> exactly one frame_err. The next full 29 frame decodes correctly, KM[7]=8'hEF.
- Hold 12 and 1C, assert clr_all for 1 cycle -> all KM=FF next cycle. A 1C make arriving in the same cycle is overridden.
- Glitch ps2_clk low for FILTER_LEN-1 cycles between frames -> no bit is sampled.
- Assert reset_n low mid-frame -> KM all FF immediately (async). The next frame after release decodes correctly.

Source files
------------

// File: rtl/ps2_kbd_matrix.sv
// PS/2 keyboard receiver and scancode decoder driving the LM80C 8x8 active-low key matrix.
// Everything runs on sys_clock; the raw PS/2 lines are synchronized and the clock is deglitched.
`timescale 1ns/1ps
module ps2_kbd_matrix #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       sys_clock,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       clr_all,
    output logic [7:0] KM [7:0],
    output logic       key_strobe,
    output logic [7:0] scancode,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN) + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    logic [1:0]  r_rst_sync;
    logic [1:0]  r_clk_sync;
    logic [1:0]  r_dat_sync;
    logic        r_clk_filt;
    logic [FW-1:0] r_filt_cnt;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_par;
    logic [15:0] r_to_cnt;
    logic        r_key_strobe;
    logic [7:0]  r_scancode;
    logic        r_frame_err;
    logic [7:0]  r_km [7:0];
    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_rst_n;
    logic        w_fall;
    logic        w_timeout;
    logic        w_make;
    logic        w_brk;
    logic        w_ext_sel;
    logic [6:0]  w_map;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] v);
        return ^v;
    endfunction

    // Base table: {valid, row, col}.
    function automatic logic [6:0] base_lookup(input logic [7:0] code);
        case (code)
            8'h66: base_lookup = {1'b1, 3'd0, 3'd0};  8'h5A: base_lookup = {1'b1, 3'd0, 3'd1};
            8'h05: base_lookup = {1'b1, 3'd0, 3'd4};  8'h06: base_lookup = {1'b1, 3'd0, 3'd5};
            8'h26: base_lookup = {1'b1, 3'd1, 3'd0};  8'h1D: base_lookup = {1'b1, 3'd1, 3'd1};
            8'h1C: base_lookup = {1'b1, 3'd1, 3'd2};  8'h25: base_lookup = {1'b1, 3'd1, 3'd3};
            8'h1A: base_lookup = {1'b1, 3'd1, 3'd4};  8'h1B: base_lookup = {1'b1, 3'd1, 3'd5};
            8'h24: base_lookup = {1'b1, 3'd1, 3'd6};  8'h12: base_lookup = {1'b1, 3'd1, 3'd7};
            8'h2E: base_lookup = {1'b1, 3'd2, 3'd0};  8'h2D: base_lookup = {1'b1, 3'd2, 3'd1};
            8'h23: base_lookup = {1'b1, 3'd2, 3'd2};  8'h36: base_lookup = {1'b1, 3'd2, 3'd3};
            8'h21: base_lookup = {1'b1, 3'd2, 3'd4};  8'h2B: base_lookup = {1'b1, 3'd2, 3'd5};
            8'h2C: base_lookup = {1'b1, 3'd2, 3'd6};  8'h22: base_lookup = {1'b1, 3'd2, 3'd7};
            8'h3D: base_lookup = {1'b1, 3'd3, 3'd0};  8'h35: base_lookup = {1'b1, 3'd3, 3'd1};
            8'h34: base_lookup = {1'b1, 3'd3, 3'd2};  8'h3E: base_lookup = {1'b1, 3'd3, 3'd3};
            8'h32: base_lookup = {1'b1, 3'd3, 3'd4};  8'h33: base_lookup = {1'b1, 3'd3, 3'd5};
            8'h3C: base_lookup = {1'b1, 3'd3, 3'd6};  8'h2A: base_lookup = {1'b1, 3'd3, 3'd7};
            8'h46: base_lookup = {1'b1, 3'd4, 3'd0};  8'h43: base_lookup = {1'b1, 3'd4, 3'd1};
            8'h3B: base_lookup = {1'b1, 3'd4, 3'd2};  8'h45: base_lookup = {1'b1, 3'd4, 3'd3};
            8'h3A: base_lookup = {1'b1, 3'd4, 3'd4};  8'h42: base_lookup = {1'b1, 3'd4, 3'd5};
            8'h44: base_lookup = {1'b1, 3'd4, 3'd6};  8'h31: base_lookup = {1'b1, 3'd4, 3'd7};
            8'h4E: base_lookup = {1'b1, 3'd5, 3'd0};  8'h4D: base_lookup = {1'b1, 3'd5, 3'd1};
            8'h4B: base_lookup = {1'b1, 3'd5, 3'd2};  8'h55: base_lookup = {1'b1, 3'd5, 3'd3};
            8'h49: base_lookup = {1'b1, 3'd5, 3'd4};  8'h4C: base_lookup = {1'b1, 3'd5, 3'd5};
            8'h54: base_lookup = {1'b1, 3'd5, 3'd6};  8'h41: base_lookup = {1'b1, 3'd5, 3'd7};
            8'h5B: base_lookup = {1'b1, 3'd6, 3'd0};  8'h52: base_lookup = {1'b1, 3'd6, 3'd1};
            8'h4A: base_lookup = {1'b1, 3'd6, 3'd2};  8'h5D: base_lookup = {1'b1, 3'd6, 3'd3};
            8'h59: base_lookup = {1'b1, 3'd6, 3'd4};  8'h0D: base_lookup = {1'b1, 3'd6, 3'd5};
            8'h0E: base_lookup = {1'b1, 3'd6, 3'd6};  8'h04: base_lookup = {1'b1, 3'd6, 3'd7};
            8'h16: base_lookup = {1'b1, 3'd7, 3'd0};  8'h76: base_lookup = {1'b1, 3'd7, 3'd1};
            8'h14: base_lookup = {1'b1, 3'd7, 3'd2};  8'h1E: base_lookup = {1'b1, 3'd7, 3'd3};
            8'h29: base_lookup = {1'b1, 3'd7, 3'd4};  8'h11: base_lookup = {1'b1, 3'd7, 3'd5};
            8'h15: base_lookup = {1'b1, 3'd7, 3'd6};  8'h0C: base_lookup = {1'b1, 3'd7, 3'd7};
            default: base_lookup = 7'd0;
        endcase
    endfunction

    // Extended (E0-prefixed) table: cursor keys and right-hand modifiers.
    function automatic logic [6:0] ext_lookup(input logic [7:0] code);
        case (code)
            8'h6B: ext_lookup = {1'b1, 3'd0, 3'd2};  8'h75: ext_lookup = {1'b1, 3'd0, 3'd3};
            8'h74: ext_lookup = {1'b1, 3'd0, 3'd6};  8'h72: ext_lookup = {1'b1, 3'd0, 3'd7};
            8'h14: ext_lookup = {1'b1, 3'd7, 3'd2};  8'h11: ext_lookup = {1'b1, 3'd7, 3'd5};
            default: ext_lookup = 7'd0;
        endcase
    endfunction

    // Reset synchronizer: assertion is immediate, release aligns to sys_clock.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // Two-flop synchronizers and the ps2_clk glitch filter.
    always_ff @(posedge sys_clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_filt <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
            if (r_clk_sync[1] == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_clk_filt <= r_clk_sync[1];
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + FW'(1);
            end
        end
    end

    assign w_fall    = r_clk_filt & ~r_clk_sync[1] & (r_filt_cnt == FW'(FILTER_LEN - 1));
    assign w_timeout = (r_bit_cnt != 4'd0) & ~w_fall & (r_to_cnt == 16'(TIMEOUT_CYC - 1));

    // Frame receiver with mid-frame idle timeout.
    always_ff @(posedge sys_clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_bit_cnt    <= 4'd0;
            r_shift      <= 8'h00;
            r_par        <= 1'b0;
            r_to_cnt     <= 16'd0;
            r_key_strobe <= 1'b0;
            r_scancode   <= 8'h00;
            r_frame_err  <= 1'b0;
        end else begin
            r_key_strobe <= 1'b0;
            r_frame_err  <= 1'b0;
            if (r_bit_cnt == 4'd0 || w_fall) r_to_cnt <= 16'd0;
            else                             r_to_cnt <= r_to_cnt + 16'd1;
            if (w_timeout) begin
                r_bit_cnt   <= 4'd0;
                r_frame_err <= 1'b1;
            end else if (w_fall) begin
                case (r_bit_cnt)
                    4'd0: begin
                        if (!r_dat_sync[1]) r_bit_cnt   <= 4'd1;
                        else                r_frame_err <= 1'b1;
                    end
                    4'd9: begin
                        r_par     <= r_dat_sync[1];
                        r_bit_cnt <= 4'd10;
                    end
                    4'd10: begin
                        r_bit_cnt <= 4'd0;
                        if (r_dat_sync[1] && odd_parity_ok({r_shift, r_par})) begin
                            r_key_strobe <= 1'b1;
                            r_scancode   <= r_shift;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    default: begin
                        r_shift   <= {r_dat_sync[1], r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                endcase
            end else begin
                r_bit_cnt <= r_bit_cnt;
            end
        end
    end

    // Decoder state register.
    always_ff @(posedge sys_clock or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Decoder next state and make/break selection for the byte just strobed.
    always_comb begin
        w_state_nxt = r_state;
        w_make      = 1'b0;
        w_brk       = 1'b0;
        w_ext_sel   = 1'b0;
        if (r_frame_err) begin
            w_state_nxt = ST_IDLE;
        end else if (r_key_strobe) begin
            w_state_nxt = ST_IDLE;
            case (r_state)
                ST_IDLE: begin
                    if (r_scancode == 8'hE0)      w_state_nxt = ST_EXT;
                    else if (r_scancode == 8'hF0) w_state_nxt = ST_BRK;
                    else if (r_scancode inside {8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'h00, 8'hFF}) w_make = 1'b0;
                    else                          w_make = 1'b1;
                end
                ST_EXT: begin
                    if (r_scancode == 8'hF0) begin
                        w_state_nxt = ST_EXT_BRK;
                    end else begin
                        w_make    = 1'b1;
                        w_ext_sel = 1'b1;
                    end
                end
                ST_BRK: w_brk = 1'b1;
                ST_EXT_BRK: begin
                    w_brk     = 1'b1;
                    w_ext_sel = 1'b1;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    assign w_map = w_ext_sel ? ext_lookup(r_scancode) : base_lookup(r_scancode);

    // Key matrix: clr_all overrides any make/break landing on the same edge.
    always_ff @(posedge sys_clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < 8; i++) r_km[i] <= 8'hFF;
        end else if (clr_all) begin
            for (int i = 0; i < 8; i++) r_km[i] <= 8'hFF;
        end else if (w_map[6] && (w_make || w_brk)) begin
            r_km[w_map[5:3]][w_map[2:0]] <= w_brk;
        end else begin
            for (int i = 0; i < 8; i++) r_km[i] <= r_km[i];
        end
    end

    assign KM         = r_km;
    assign key_strobe = r_key_strobe;
    assign scancode   = r_scancode;
    assign frame_err  = r_frame_err;
endmodule

// File: tb/tb_ps2_kbd_matrix.sv
// Bench for ps2_kbd_matrix: directed PS/2 frames, a key-matrix model driven by an expected-byte
// queue and a prefix-state decoder, checked every cycle, plus literal spot checks.
`timescale 1ns/1ps
module tb_ps2_kbd_matrix;
    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 50000;

    logic       sys_clock = 1'b0;
    logic       reset_n, ps2_clk, ps2_data, clr_all;
    logic [7:0] km [7:0];
    logic       key_strobe, frame_err;
    logic [7:0] scancode;

    int n_cmp = 0, n_bad = 0, n_strobe = 0, n_err = 0;
    logic [7:0] exp_q [$];
    int kpos [int];
    logic [7:0] m_km [8];
    bit m_ext = 1'b0, m_brk = 1'b0;
    bit pend_valid = 1'b0, pend_val;
    int pend_pos;

    ps2_kbd_matrix #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .sys_clock(sys_clock), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .clr_all(clr_all), .KM(km), .key_strobe(key_strobe), .scancode(scancode), .frame_err(frame_err));

    always #5 sys_clock = ~sys_clock;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // Drives one frame; only frames that should decode are queued as expected bytes.
    task automatic send(input logic [7:0] b, input bit bad_par = 1'b0, input int nbits = 11);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        if (!bad_par && nbits == 11) exp_q.push_back(b);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (8) @(negedge sys_clock);
            ps2_clk = 1'b0;
            repeat (16) @(negedge sys_clock);
            ps2_clk = 1'b1;
            repeat (8) @(negedge sys_clock);
        end
        ps2_data = 1'b1;
        repeat (16) @(negedge sys_clock);
    endtask

    // Model of the prefix decoder: returns the matrix update a byte implies, if any.
    task automatic model_byte(input logic [7:0] b);
        int key;
        if (b == 8'hE0 && !m_ext && !m_brk) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0 && !m_brk) begin
            m_brk = 1'b1;
        end else begin
            key = (m_ext ? 256 : 0) + int'(b);
            if (!(!m_ext && !m_brk && (b inside {8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'h00, 8'hFF}))
                && kpos.exists(key)) begin
                pend_valid = 1'b1;
                pend_pos   = kpos[key];
                pend_val   = m_brk;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    // Per-cycle comparison of the whole matrix, strobed bytes and error pulses against the model.
    initial begin
        bit c_clr;
        bit row_bad;
        for (int i = 0; i < 8; i++) m_km[i] = 8'hFF;
        forever begin
            @(posedge sys_clock);
            c_clr = clr_all;
            @(negedge sys_clock);
            if (!reset_n) begin
                for (int i = 0; i < 8; i++) m_km[i] = 8'hFF;
                m_ext = 1'b0; m_brk = 1'b0; pend_valid = 1'b0;
            end else begin
                if (pend_valid) m_km[pend_pos / 8][pend_pos % 8] = pend_val;
                pend_valid = 1'b0;
                if (c_clr) for (int i = 0; i < 8; i++) m_km[i] = 8'hFF;
            end
            row_bad = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (km[i] !== m_km[i] && !row_bad) begin
                    row_bad = 1'b1;
                    if (n_bad < 30) $display("FAIL km_model row %0d: got %h want %h at %0t", i, km[i], m_km[i], $time);
                end
            end
            n_cmp++;
            if (row_bad) n_bad++;
            if (key_strobe === 1'b1) begin
                n_strobe++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL strobe_unexpected: got scancode %h want no strobe", scancode);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (scancode !== e) begin
                        n_bad++;
                        $display("FAIL scancode_model: got %h want %h", scancode, e);
                    end
                    model_byte(e);
                end
            end
            if (frame_err === 1'b1) begin
                n_err++;
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end
    end

    initial begin
        #(150000 * 10);
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, e0;
        kpos[8'h1C] = 10; kpos[8'h1B] = 13; kpos[8'h5A] = 1;  kpos[8'h12] = 15;
        kpos[8'h59] = 52; kpos[8'h29] = 60; kpos[8'h66] = 0;  kpos[8'h16] = 56;
        kpos[256 + 8'h75] = 3; kpos[256 + 8'h72] = 7; kpos[256 + 8'h6B] = 2; kpos[256 + 8'h74] = 6;
        ps2_clk = 1'b1; ps2_data = 1'b1; clr_all = 1'b0; reset_n = 1'b0;
        repeat (5) @(negedge sys_clock);
        reset_n = 1'b1;
        repeat (5) @(negedge sys_clock);
        for (int i = 0; i < 8; i++) chk($sformatf("reset_km%0d", i), 32'(km[i]), 32'hFF);
        chk("reset_scancode", 32'(scancode), 32'h00);
        chk("reset_strobe", 32'(key_strobe), 32'h0);
        chk("reset_ferr", 32'(frame_err), 32'h0);

        s0 = n_strobe;
        send(8'h1C);
        chk("make_A_strobes", n_strobe - s0, 1);
        chk("make_A_code", 32'(scancode), 32'h1C);
        chk("make_A_km1", 32'(km[1]), 32'hFB);
        chk("make_A_km0", 32'(km[0]), 32'hFF);

        s0 = n_strobe;
        send(8'hF0); send(8'h1C);
        chk("brk_A_strobes", n_strobe - s0, 2);
        chk("brk_A_km1", 32'(km[1]), 32'hFF);

        send(8'hE0); send(8'h75);
        chk("up_make_km0", 32'(km[0]), 32'hF7);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("up_brk_km0", 32'(km[0]), 32'hFF);
        send(8'h75);
        chk("bare75_km0", 32'(km[0]), 32'hFF);

        s0 = n_strobe; e0 = n_err;
        send(8'h5A, 1'b1);
        chk("badpar_ferr", n_err - e0, 1);
        chk("badpar_strobes", n_strobe - s0, 0);
        chk("badpar_km0", 32'(km[0]), 32'hFF);
        send(8'h5A);
        chk("enter_km0", 32'(km[0]), 32'hFD);

        e0 = n_err;
        send(8'h29, 1'b0, 4);
        repeat (TIMEOUT_CYC + 10) @(negedge sys_clock);
        chk("timeout_ferr", n_err - e0, 1);
        send(8'h29);
        chk("space_km7", 32'(km[7]), 32'hEF);

        send(8'h12); send(8'h1C);
        chk("shift_A_km1", 32'(km[1]), 32'h7B);
        @(negedge sys_clock); clr_all = 1'b1;
        @(negedge sys_clock); clr_all = 1'b0;
        for (int i = 0; i < 8; i++) chk($sformatf("clr_km%0d", i), 32'(km[i]), 32'hFF);
        fork
            send(8'h1C);
            begin
                int k;
                k = 0;
                while (key_strobe !== 1'b1 && k < 2000) begin
                    @(negedge sys_clock);
                    k++;
                end
                chk("clr_make_strobe_seen", 32'(k < 2000), 32'h1);
                clr_all = 1'b1;
                @(negedge sys_clock);
                clr_all = 1'b0;
            end
        join
        chk("clr_over_make_km1", 32'(km[1]), 32'hFF);

        s0 = n_strobe; e0 = n_err;
        ps2_clk = 1'b0;
        repeat (FILTER_LEN - 1) @(negedge sys_clock);
        ps2_clk = 1'b1;
        repeat (40) @(negedge sys_clock);
        chk("glitch_ferr", n_err - e0, 0);
        chk("glitch_strobes", n_strobe - s0, 0);
        send(8'h16);
        chk("one_km7", 32'(km[7]), 32'hFE);

        fork
            send(8'h1C, 1'b0, 5);
            begin
                repeat (100) @(negedge sys_clock);
                #2 reset_n = 1'b0;
                #1 chk("async_rst_km7", 32'(km[7]), 32'hFF);
            end
        join
        @(negedge sys_clock); reset_n = 1'b1;
        repeat (10) @(negedge sys_clock);
        send(8'h66);
        chk("post_rst_code", 32'(scancode), 32'h66);
        chk("post_rst_km0", 32'(km[0]), 32'hFE);
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
